uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_hold.sv | 57 +++++
 rtl/uart_tx_param.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//   State encodings (one-hot), default frame/oversample constants, and a
//   small constant helper used to size counters.
package uart_pkg;

   localparam int D_BIT_DEF      = 8;
   localparam int OVERSAMPLE_DEF = 16;
   localparam int SB_TICK_DEF    = 16;

   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      START  = 5'b00010,
      DATA   = 5'b00100,
      PARITY = 5'b01000,
      STOP   = 5'b10000
   } uart_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// uart_tx_hold -- one-entry holding register in front of the TX shifter.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   start_i        : load request, honoured only while ready_o is 1
//   data_i         : byte to hold
//   drain_i        : the FSM has taken the held byte
//   ready_o        : registered, high while the holding register is empty
//   valid_o/data_o : holding register contents
module uart_tx_hold
   import uart_pkg::*;
#(
   parameter int D_BIT = D_BIT_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [D_BIT-1:0] data_i,
   input  logic             drain_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [D_BIT-1:0] data_o
);

   logic             valid_q, valid_d;
   logic             ready_q, ready_d;
   logic [D_BIT-1:0] data_q, data_d;

   // A drain only happens while valid_q=1, when ready_q is already 0, so a
   // start on the drain cycle is dropped rather than queued.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (drain_i) begin
         valid_d = 1'b0;
      end else if (start_i && ready_q) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
      ready_d = !valid_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param -- parameterised UART transmitter with a 1-entry holding
// register and back-to-back frame support.
//   clk, rst_n   : clock, synchronous active-low reset
//   tick_in      : one-clk baud-oversample enable
//   dato_in      : byte to send, taken when tx_start and tx_ready are both 1
//   tx_start     : load request
//   tx_ready     : holding register empty
//   dato_out     : registered serial line, idle high
//   tx_busy      : frame in progress
//   tx_done_tick : one-clk pulse on the last tick of the stop period
// Optional feature: define TX_PARITY_EN to insert a parity bit (even, or odd
// when PARITY_ODD=1) between the data bits and the stop period.
//
// state  | meaning
// IDLE   | line high, waiting for a held byte and a tick
// START  | start bit (0) for OVERSAMPLE ticks
// DATA   | D_BIT data bits, LSB first, OVERSAMPLE ticks each
// PARITY | parity bit for OVERSAMPLE ticks (TX_PARITY_EN only)
// STOP   | line high for SB_TICK ticks; chains to START if a byte is held
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int D_BIT      = D_BIT_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int SB_TICK    = SB_TICK_DEF,
   parameter int PARITY_ODD = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_in,
   input  logic [D_BIT-1:0] dato_in,
   input  logic             tx_start,
   output logic             tx_ready,
   output logic             dato_out,
   output logic             tx_busy,
   output logic             tx_done_tick
);

   localparam int TW = $clog2(max_int(OVERSAMPLE, SB_TICK));
   localparam int BW = $clog2(D_BIT + 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(D_BIT - 1);

   if (D_BIT < 5 || D_BIT > 9) begin : g_bad_d_bit
      $error("uart_tx_param: D_BIT must be 5..9");
   end
   if (OVERSAMPLE < 8 || OVERSAMPLE > 32) begin : g_bad_oversample
      $error("uart_tx_param: OVERSAMPLE must be 8..32");
   end
   if (SB_TICK < 1 || SB_TICK > 32) begin : g_bad_sb_tick
      $error("uart_tx_param: SB_TICK must be 1..32");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_tx_param: PARITY_ODD must be 0 or 1");
   end

   uart_state_e      state_q, state_d;
   logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [D_BIT-1:0] shift_q, shift_d;
   logic             dato_out_q, dato_out_d;
   logic             drain;
   logic             frame_end;
   logic             hold_valid;
   logic [D_BIT-1:0] hold_data;
`ifdef TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   uart_tx_hold #(.D_BIT(D_BIT)) u_hold (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .start_i (tx_start),
      .data_i  (dato_in),
      .drain_i (drain),
      .ready_o (tx_ready),
      .valid_o (hold_valid),
      .data_o  (hold_data)
   );

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      drain      = 1'b0;
      frame_end  = 1'b0;
`ifdef TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         IDLE: begin
            tick_cnt_d = '0;
            if (tick_in && hold_valid) begin
               state_d = START;
               drain   = 1'b1;
            end
         end
         START: if (tick_in) begin
            if (tick_cnt_q == BIT_LAST) begin
               tick_cnt_d = '0;
               state_d    = DATA;
            end else begin
               tick_cnt_d = tick_cnt_q + TW'(1);
            end
         end
         DATA: if (tick_in) begin
            if (tick_cnt_q == BIT_LAST) begin
               tick_cnt_d = '0;
               shift_d    = shift_q >> 1;
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
`ifdef TX_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               tick_cnt_d = tick_cnt_q + TW'(1);
            end
         end
`ifdef TX_PARITY_EN
         PARITY: if (tick_in) begin
            if (tick_cnt_q == BIT_LAST) begin
               tick_cnt_d = '0;
               state_d    = STOP;
            end else begin
               tick_cnt_d = tick_cnt_q + TW'(1);
            end
         end
`endif
         STOP: if (tick_in) begin
            if (tick_cnt_q == STOP_LAST) begin
               tick_cnt_d = '0;
               frame_end  = 1'b1;
               if (hold_valid) begin
                  state_d = START;
                  drain   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + TW'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
         end
      endcase

      // Taking a byte from the holding register always starts a new frame.
      if (drain) begin
         shift_d   = hold_data;
         bit_cnt_d = '0;
`ifdef TX_PARITY_EN
         parity_d  = (^hold_data) ^ (PARITY_ODD != 0);
`endif
      end

      // The line is registered, so it is driven from the next state.
      case (state_d)
         START:   dato_out_d = 1'b0;
         DATA:    dato_out_d = shift_d[0];
`ifdef TX_PARITY_EN
         PARITY:  dato_out_d = parity_d;
`endif
         default: dato_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         dato_out_q <= 1'b1;
`ifdef TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         dato_out_q <= dato_out_d;
`ifdef TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign dato_out     = dato_out_q;
   assign tx_busy      = (state_q != IDLE);
   assign tx_done_tick = frame_end && rst_n;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param -- directed bench for uart_tx_param with default
// parameters (8 data bits, 16x oversample, 1 stop bit, tick every 4 clks).
// A tick-slot queue model predicts the line, handshake and done pulse on
// every cycle; a tick-counting line decoder and literal expectations pin
// the model.
module tb_uart_tx_param;

   localparam int DB = 8;
   localparam int OS = 16;
   localparam int SB = 16;
`ifdef TX_PARITY_EN
   localparam int PAR_SLOTS = 1;
`else
   localparam int PAR_SLOTS = 0;
`endif
   localparam int NSLOT      = 1 + DB + PAR_SLOTS + 1;
   localparam int FRAME_CLKS = (OS * (1 + DB + PAR_SLOTS) + SB) * 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_in;
   logic       tick_en = 1'b1;
   logic [7:0] dato_in;
   logic       tx_start;
   logic       tx_ready;
   logic       dato_out;
   logic       tx_busy;
   logic       tx_done_tick;

   uart_tx_param dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_in      (tick_in),
      .dato_in      (dato_in),
      .tx_start     (tx_start),
      .tx_ready     (tx_ready),
      .dato_out     (dato_out),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model: holding register + per-tick line levels ------
   logic       m_q[$];
   logic       m_hold_valid = 1'b0;
   logic [7:0] m_hold_data  = '0;
   logic       pre_valid;
   bit         tick_at_edge = 1'b0;
   bit         check_en     = 1'b0;
   int         cyc          = 0;

   task automatic build_frame(input logic [7:0] d);
      for (int k = 0; k < OS; k++) m_q.push_back(1'b0);
      for (int i = 0; i < DB; i++)
         for (int k = 0; k < OS; k++) m_q.push_back(d[i]);
`ifdef TX_PARITY_EN
      for (int k = 0; k < OS; k++) m_q.push_back(^d);
`endif
      for (int k = 0; k < SB; k++) m_q.push_back(1'b1);
   endtask

   always @(posedge clk) begin
      cyc++;
      tick_at_edge = tick_in && rst_n;
      if (!rst_n) begin
         m_q.delete();
         m_hold_valid = 1'b0;
         m_hold_data  = '0;
      end else begin
         pre_valid = m_hold_valid;
         if (tick_in) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (m_q.size() == 0 && pre_valid) begin
               build_frame(m_hold_data);
               m_hold_valid = 1'b0;
            end
         end
         if (tx_start && !pre_valid) begin
            m_hold_valid = 1'b1;
            m_hold_data  = dato_in;
         end
      end
   end

   // ---------------- per-cycle compare + line decoder ---------------------
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         fall_cyc = 0;
   int         fall_gap = 0;
   bit         dec_active = 1'b0;
   int         dec_tk = 0;
   int         slot;
   int         dec_err = 0;
   logic [7:0] dec_byte;
   logic [7:0] rx_q[$];
   logic       dec_par_q[$];

   always @(negedge clk) begin
      if (check_en) begin
         chk("line",  dato_out,     (m_q.size() > 0) ? m_q[0] : 1'b1);
         chk("ready", tx_ready,     !m_hold_valid);
         chk("busy",  tx_busy,      m_q.size() != 0);
         chk("done",  tx_done_tick, rst_n && tick_in && m_q.size() == 1);
      end
      if (tx_done_tick === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!rst_n) begin
         dec_active = 1'b0;
      end else if (!dec_active) begin
         if (dato_out === 1'b0) begin
            dec_active = 1'b1;
            dec_tk     = 0;
            dec_byte   = '0;
            fall_cyc   = cyc;
            fall_gap   = cyc - done_cyc;
         end
      end else if (tick_at_edge) begin
         dec_tk++;
         if (dec_tk % OS == OS / 2) begin
            slot = dec_tk / OS;
            if (slot == 0) begin
               if (dato_out !== 1'b0) dec_err++;
            end else if (slot <= DB) begin
               dec_byte[slot-1] = dato_out;
            end else if (slot == NSLOT - 1) begin
               if (dato_out !== 1'b1) dec_err++;
               rx_q.push_back(dec_byte);
               dec_active = 1'b0;
            end else begin
               dec_par_q.push_back(dato_out);
            end
         end
      end
   end

   // ---------------- tick generator: one pulse every 4 clks ---------------
   initial begin
      int div;
      div     = 0;
      tick_in = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         div     = (div + 1) % 4;
         tick_in = tick_en && (div == 0);
      end
   end

   // ---------------- stimulus ---------------------------------------------
   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      tx_start = 1'b1;
      dato_in  = b;
      clk_wait(1);
      tx_start = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int n;
      n = 0;
      while (!(tx_busy === 1'b0 && tx_ready === 1'b1) && n < max_cyc) begin
         clk_wait(1);
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         failures++;
         $display("FAIL timeout_%s: still busy after %0d clks, required idle", tag, n);
      end
   endtask

   task automatic wait_line_low(input int max_cyc, input string tag);
      int n;
      n = 0;
      while (dato_out !== 1'b0 && n < max_cyc) begin
         clk_wait(1);
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         failures++;
         $display("FAIL timeout_%s: line high after %0d clks, required start bit", tag, n);
      end
   endtask

   logic [7:0] exp_rx [5];
   logic       exp_par[5];
   int         done_before;

   initial begin
      exp_rx  = '{8'h55, 8'hA3, 8'h0F, 8'h07, 8'h3C};
      exp_par = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      rst_n    = 1'b0;
      tx_start = 1'b0;
      dato_in  = '0;
      tick_en  = 1'b1;
      clk_wait(2);
      check_en = 1'b1;
      @(negedge clk);
      chk("rst_line",  dato_out,     1);
      chk("rst_ready", tx_ready,     1);
      chk("rst_busy",  tx_busy,      0);
      chk("rst_done",  tx_done_tick, 0);
      clk_wait(1);
      rst_n = 1'b1;
      clk_wait(3);

      // single frame 0x55
      send(8'h55);
      wait_idle(2000, "55");
      chk("done_cnt_55",  done_cnt, 1);
      chk("busy_after_55", tx_busy, 0);
      chk("dur_55", done_cyc - fall_cyc, FRAME_CLKS - 1);
      chk("rx_55", (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'hxx, 8'h55);

      // back-to-back 0xA3 / 0x0F, 0x77 rejected while 0x0F is held
      send(8'hA3);
      clk_wait(150);
      chk("ready_before_0f", tx_ready, 1);
      send(8'h0F);
      clk_wait(5);
      chk("ready_full", tx_ready, 0);
      send(8'h77);
      chk("ready_after_77", tx_ready, 0);
      wait_idle(3000, "a3_0f");
      chk("done_cnt_b2b", done_cnt, 3);
      chk("b2b_gap", fall_gap, 1);

      // 0x07: parity bit 1 under even parity
      send(8'h07);
      wait_idle(2000, "07");
      chk("done_cnt_07", done_cnt, 4);
`ifdef TX_PARITY_EN
      chk("parity_07", (dec_par_q.size() > 0) ? dec_par_q[dec_par_q.size()-1] : 1'bx, 1);
      chk("dur_07", done_cyc - fall_cyc, 11 * 64 - 1);
`endif

      // reset during data bit 3 of 0xC4
      send(8'hC4);
      clk_wait(290);
      chk("c4_busy", tx_busy, 1);
      done_before = done_cnt;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_line",  dato_out,     1);
      chk("abort_ready", tx_ready,     1);
      chk("abort_done",  tx_done_tick, 0);
      clk_wait(1);
      rst_n = 1'b1;
      clk_wait(200);
      chk("abort_no_done", done_cnt, done_before);
      chk("abort_busy", tx_busy, 0);

      // tick_in held low for 500 clks in the start bit of 0x3C
      send(8'h3C);
      wait_line_low(20, "3c");
      clk_wait(20);
      tick_en = 1'b0;
      clk_wait(500);
      chk("pause_line", dato_out, 0);
      chk("pause_busy", tx_busy, 1);
      tick_en = 1'b1;
      wait_idle(3000, "3c");
      chk("dur_pause", done_cyc - fall_cyc, FRAME_CLKS - 1 + 500);
      chk("done_cnt_end", done_cnt, 5);

      // everything seen on the line
      chk("rx_count", rx_q.size(), 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("rx_byte%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_rx[i]);
      chk("frame_fmt_err", dec_err, 0);
`ifdef TX_PARITY_EN
      chk("par_count", dec_par_q.size(), 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("par%0d", i), (i < dec_par_q.size()) ? dec_par_q[i] : 1'bx, exp_par[i]);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
